// File: rtl/ex_pkg.sv
// Shared types for the execution-side functional-unit array: issue-type codes,
// tag/ROB widths, unit indices and the pipeline entry record.
package ex_pkg;

    localparam logic [2:0] EX_ALU  = 3'd0;
    localparam logic [2:0] EX_MULT = 3'd1;
    localparam logic [2:0] EX_LD   = 3'd2;
    localparam logic [2:0] EX_SV   = 3'd3;

    localparam int unsigned TAG_W = 6;
    localparam int unsigned ROB_W = 5;

    // Unit index doubles as the issue type code and as CDB priority rank.
    typedef enum logic [1:0] {
        U_ALU  = 2'd0,
        U_MULT = 2'd1,
        U_LD   = 2'd2,
        U_SV   = 2'd3
    } ex_unit_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
    } ex_entry_t;

endpackage

// File: rtl/ex_fu_pipe.sv
// One fixed-latency functional unit: a two-wide LAT-stage shift register feeding
// a CAP-deep first-word-fall-through completion FIFO, with occupancy and full tracking.
module ex_fu_pipe
    import ex_pkg::*;
#(
    parameter int unsigned LAT = 1,
    parameter int unsigned CAP = 4,
    parameter int unsigned OW  = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    acc_cnt_i,
    input  ex_entry_t     ent0_i,
    input  ex_entry_t     ent1_i,
    input  logic          pop_i,
    output ex_entry_t     head_o,
    output logic [OW-1:0] occ_o,
    output logic          full_o
);

    localparam int unsigned PW = (CAP > 1) ? $clog2(CAP) : 1;

    ex_entry_t      st0_q [LAT];
    ex_entry_t      st1_q [LAT];
    ex_entry_t      mem_q [CAP];
    logic [PW-1:0]  rd_q, wr_q, wr1, rd_d, wr_d;
    logic [OW-1:0]  cnt_q, cnt_d, occ_q, occ_d;
    logic           full_q;
    ex_entry_t      in0, in1;
    logic           push0, push1;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(CAP - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in0       = ent0_i;
        in0.valid = ent0_i.valid && (acc_cnt_i != 2'd0);
        in1       = ent1_i;
        in1.valid = ent1_i.valid && (acc_cnt_i == 2'd2);
        // Slot 1 is only ever filled alongside slot 0, so push1 implies push0.
        push0     = st0_q[LAT-1].valid;
        push1     = st1_q[LAT-1].valid;
        wr1       = inc(wr_q);
        wr_d      = push1 ? inc(wr1) : (push0 ? wr1 : wr_q);
        rd_d      = pop_i ? inc(rd_q) : rd_q;
        cnt_d     = cnt_q + OW'(push0) + OW'(push1) - OW'(pop_i);
        occ_d     = occ_q + OW'(acc_cnt_i) - OW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                st0_q[i] <= '0;
                st1_q[i] <= '0;
            end
            for (int unsigned i = 0; i < CAP; i++) begin
                mem_q[i] <= '0;
            end
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            st0_q[0] <= in0;
            st1_q[0] <= in1;
            for (int unsigned i = 1; i < LAT; i++) begin
                st0_q[i] <= st0_q[i-1];
                st1_q[i] <= st1_q[i-1];
            end
            if (push0) mem_q[wr_q] <= st0_q[LAT-1];
            if (push1) mem_q[wr1]  <= st1_q[LAT-1];
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            occ_q  <= occ_d;
            full_q <= (occ_d >= OW'(CAP - 1));
        end
    end

    always_comb begin
        head_o       = mem_q[rd_q];
        head_o.valid = mem_q[rd_q].valid && (cnt_q != '0);
    end

    assign occ_o  = occ_q;
    assign full_o = full_q;

endmodule

// File: rtl/ex_fu_array.sv
// Execution endpoint of the RS issue interface: routes A/B issues to four unit
// pipes, drops over-capacity accepts, and arbitrates results onto two CDB ports.
module ex_fu_array
    import ex_pkg::*;
#(
    parameter int unsigned CAP      = 4,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned LD_LAT   = 2,
    parameter int unsigned SV_LAT   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] rs_issueA_out,
    input  logic [2:0] rs_issueB_out,
    input  logic       rs_issueArdy_out,
    input  logic       rs_issueBrdy_out,
    input  logic [5:0] rs_TA_out,
    input  logic [5:0] rs_TB_out,
    input  logic [4:0] rs_rob_idxA_out,
    input  logic [4:0] rs_rob_idxB_out,
    output logic       ex_alu_full,
    output logic       ex_mulq_full,
    output logic       ex_ld_full,
    output logic       ex_sv_full,
    output logic [5:0] ex_cm_cdbAIdx,
    output logic [5:0] ex_cm_cdbBIdx,
    output logic       ex_cm_cdbA_en,
    output logic       ex_cm_cdbB_en,
    output logic [4:0] ex_cm_robIdxA,
    output logic [4:0] ex_cm_robIdxB,
    output logic       ex_sv_done,
    output logic [4:0] ex_sv_robIdx,
    output logic       ex_overflow
);

    localparam int unsigned OW = $clog2(CAP + 2) + 1;
    localparam int unsigned NU = 4;
    localparam int unsigned LATV [NU] = '{ALU_LAT, MULT_LAT, LD_LAT, SV_LAT};

    logic [NU-1:0] req_a, req_b, acc_a, acc_b, pop, full;
    logic [1:0]    acc_cnt [NU];
    logic [OW-1:0] occ     [NU];
    int            room    [NU];
    ex_entry_t     ent_a, ent_b;
    ex_entry_t     ent0 [NU];
    ex_entry_t     ent1 [NU];
    ex_entry_t     head [NU];
    ex_entry_t     cdb_a, cdb_b, sv_ent;
    ex_entry_t     cdb_a_q, cdb_b_q, sv_q;
    logic          a_taken, b_taken, drop, ovf_q;

    always_comb begin
        pop     = '0;
        cdb_a   = '0;
        cdb_b   = '0;
        a_taken = 1'b0;
        b_taken = 1'b0;
        // Walk units LD(2) -> MULT(1) -> ALU(0): first ready head takes A, next takes B.
        for (int unsigned k = 0; k < 3; k++) begin
            if (head[2-k].valid) begin
                if (!a_taken) begin
                    cdb_a     = head[2-k];
                    pop[2-k]  = 1'b1;
                    a_taken   = 1'b1;
                end else if (!b_taken) begin
                    cdb_b     = head[2-k];
                    pop[2-k]  = 1'b1;
                    b_taken   = 1'b1;
                end
            end
        end
        pop[U_SV] = head[U_SV].valid;
        sv_ent    = '0;
        if (head[U_SV].valid) begin
            sv_ent.valid = 1'b1;
            sv_ent.rob   = head[U_SV].rob;
        end
    end

    always_comb begin
        ent_a = '{valid: 1'b1, tag: rs_TA_out, rob: rs_rob_idxA_out};
        ent_b = '{valid: 1'b1, tag: rs_TB_out, rob: rs_rob_idxB_out};
        req_a = '0;
        req_b = '0;
        acc_a = '0;
        acc_b = '0;
        for (int unsigned u = 0; u < NU; u++) begin
            req_a[u]   = rs_issueArdy_out && (rs_issueA_out == 3'(u));
            req_b[u]   = rs_issueBrdy_out && (rs_issueB_out == 3'(u));
            // Same-edge drain frees a slot; A claims it before B.
            room[u]    = int'(CAP) - int'(occ[u]) + int'(pop[u]);
            acc_a[u]   = req_a[u] && (room[u] >= 1);
            acc_b[u]   = req_b[u] && (room[u] >= (acc_a[u] ? 2 : 1));
            acc_cnt[u] = {1'b0, acc_a[u]} + {1'b0, acc_b[u]};
            ent0[u]    = acc_a[u] ? ent_a : ent_b;
            ent1[u]    = ent_b;
        end
        drop = |(req_a & ~acc_a) || |(req_b & ~acc_b);
    end

    for (genvar g = 0; g < NU; g++) begin : g_unit
        ex_fu_pipe #(
            .LAT (LATV[g]),
            .CAP (CAP),
            .OW  (OW)
        ) u_pipe (
            .clk_i     (clock),
            .rst_ni    (reset),
            .acc_cnt_i (acc_cnt[g]),
            .ent0_i    (ent0[g]),
            .ent1_i    (ent1[g]),
            .pop_i     (pop[g]),
            .head_o    (head[g]),
            .occ_o     (occ[g]),
            .full_o    (full[g])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_a_q <= '0;
            cdb_b_q <= '0;
            sv_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cdb_a_q <= cdb_a;
            cdb_b_q <= cdb_b;
            sv_q    <= sv_ent;
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign ex_alu_full   = full[U_ALU];
    assign ex_mulq_full  = full[U_MULT];
    assign ex_ld_full    = full[U_LD];
    assign ex_sv_full    = full[U_SV];
    assign ex_cm_cdbA_en = cdb_a_q.valid;
    assign ex_cm_cdbAIdx = cdb_a_q.tag;
    assign ex_cm_robIdxA = cdb_a_q.rob;
    assign ex_cm_cdbB_en = cdb_b_q.valid;
    assign ex_cm_cdbBIdx = cdb_b_q.tag;
    assign ex_cm_robIdxB = cdb_b_q.rob;
    assign ex_sv_done    = sv_q.valid;
    assign ex_sv_robIdx  = sv_q.rob;
    assign ex_overflow   = ovf_q;

endmodule

// File: tb/tb_ex_fu_array.sv
// Bench for ex_fu_array: latency table, hand-written arbitration/back-pressure/
// overflow/store/reset sequences, and randomized traffic against a queue model.
module tb_ex_fu_array;
    import ex_pkg::*;

    localparam int unsigned CAP      = 4;
    localparam int unsigned ALU_LAT  = 1;
    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned LD_LAT   = 2;
    localparam int unsigned SV_LAT   = 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rs_issueA_out, rs_issueB_out;
    logic       rs_issueArdy_out, rs_issueBrdy_out;
    logic [5:0] rs_TA_out, rs_TB_out;
    logic [4:0] rs_rob_idxA_out, rs_rob_idxB_out;
    logic       ex_alu_full, ex_mulq_full, ex_ld_full, ex_sv_full;
    logic [5:0] ex_cm_cdbAIdx, ex_cm_cdbBIdx;
    logic       ex_cm_cdbA_en, ex_cm_cdbB_en;
    logic [4:0] ex_cm_robIdxA, ex_cm_robIdxB;
    logic       ex_sv_done;
    logic [4:0] ex_sv_robIdx;
    logic       ex_overflow;

    always #5 clock = ~clock;

    ex_fu_array #(
        .CAP      (CAP),
        .ALU_LAT  (ALU_LAT),
        .MULT_LAT (MULT_LAT),
        .LD_LAT   (LD_LAT),
        .SV_LAT   (SV_LAT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rs_issueA_out    (rs_issueA_out),
        .rs_issueB_out    (rs_issueB_out),
        .rs_issueArdy_out (rs_issueArdy_out),
        .rs_issueBrdy_out (rs_issueBrdy_out),
        .rs_TA_out        (rs_TA_out),
        .rs_TB_out        (rs_TB_out),
        .rs_rob_idxA_out  (rs_rob_idxA_out),
        .rs_rob_idxB_out  (rs_rob_idxB_out),
        .ex_alu_full      (ex_alu_full),
        .ex_mulq_full     (ex_mulq_full),
        .ex_ld_full       (ex_ld_full),
        .ex_sv_full       (ex_sv_full),
        .ex_cm_cdbAIdx    (ex_cm_cdbAIdx),
        .ex_cm_cdbBIdx    (ex_cm_cdbBIdx),
        .ex_cm_cdbA_en    (ex_cm_cdbA_en),
        .ex_cm_cdbB_en    (ex_cm_cdbB_en),
        .ex_cm_robIdxA    (ex_cm_robIdxA),
        .ex_cm_robIdxB    (ex_cm_robIdxB),
        .ex_sv_done       (ex_sv_done),
        .ex_sv_robIdx     (ex_sv_robIdx),
        .ex_overflow      (ex_overflow)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] obs();
        return {ex_alu_full, ex_mulq_full, ex_ld_full, ex_sv_full,
                ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_robIdxA,
                ex_cm_cdbB_en, ex_cm_cdbBIdx, ex_cm_robIdxB,
                ex_sv_done, ex_sv_robIdx, ex_overflow};
    endfunction

    function automatic logic [29:0] cdb_obs();
        return {ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_robIdxA,
                ex_cm_cdbB_en, ex_cm_cdbBIdx, ex_cm_robIdxB,
                ex_sv_done, ex_sv_robIdx};
    endfunction

    // Reference model: each unit is a list of accepted entries in issue order,
    // each stamped with the edge at which it becomes visible at the FIFO head.
    typedef struct {
        logic [5:0] tag;
        logic [4:0] rob;
        int         ready;
    } ment_t;

    ment_t       mq [4][$];
    int          edge_n = 0;
    logic        m_ovf  = 1'b0;
    logic [34:0] exp_v  = '0;

    function automatic int lat_of(input int u);
        case (u)
            0:       return int'(ALU_LAT);
            1:       return int'(MULT_LAT);
            2:       return int'(LD_LAT);
            default: return int'(SV_LAT);
        endcase
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 4; u++) mq[u].delete();
        m_ovf = 1'b0;
        exp_v = '0;
    endtask

    task automatic model_accept(input logic rdy, input logic [2:0] typ,
                                input logic [5:0] tag, input logic [4:0] rob);
        ment_t m;
        int    u;
        if (rdy && typ < 3'd4) begin
            u = int'(typ);
            if (mq[u].size() < int'(CAP)) begin
                m.tag   = tag;
                m.rob   = rob;
                m.ready = edge_n + lat_of(u);
                mq[u].push_back(m);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        ment_t      m;
        int         ng, u;
        logic       aen, ben, sd;
        logic [5:0] at, bt;
        logic [4:0] ar, br, sr;
        logic [3:0] f;
        edge_n++;
        if (!reset) begin
            model_reset();
            return;
        end
        {aen, at, ar, ben, bt, br, sd, sr} = '0;
        ng = 0;
        for (int k = 0; k < 3; k++) begin
            u = 2 - k;
            if (ng < 2 && mq[u].size() > 0 && mq[u][0].ready < edge_n) begin
                m = mq[u].pop_front();
                if (ng == 0) {aen, at, ar} = {1'b1, m.tag, m.rob};
                else         {ben, bt, br} = {1'b1, m.tag, m.rob};
                ng++;
            end
        end
        if (mq[3].size() > 0 && mq[3][0].ready < edge_n) begin
            m = mq[3].pop_front();
            {sd, sr} = {1'b1, m.rob};
        end
        model_accept(rs_issueArdy_out, rs_issueA_out, rs_TA_out, rs_rob_idxA_out);
        model_accept(rs_issueBrdy_out, rs_issueB_out, rs_TB_out, rs_rob_idxB_out);
        for (int i = 0; i < 4; i++) f[3-i] = (mq[i].size() >= int'(CAP) - 1);
        exp_v = {f, aen, at, ar, ben, bt, br, sd, sr, m_ovf};
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("model", 64'(obs()), 64'(exp_v));
    endtask

    task automatic drive(input logic ra, input logic [2:0] ta, input logic [5:0] ga, input logic [4:0] oa,
                         input logic rb, input logic [2:0] tb, input logic [5:0] gb, input logic [4:0] ob);
        rs_issueArdy_out = ra; rs_issueA_out = ta; rs_TA_out = ga; rs_rob_idxA_out = oa;
        rs_issueBrdy_out = rb; rs_issueB_out = tb; rs_TB_out = gb; rs_rob_idxB_out = ob;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 6'd0, 5'd0, 1'b0, 3'd0, 6'd0, 5'd0);
    endtask

    task automatic apply_reset(input int n);
        idle();
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_async", 64'(obs()), 64'(0));
        repeat (n) cycle();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [2:0] typ;
        logic       portb;
        logic [5:0] tag;
        logic [4:0] rob;
        int         lat;
    } vec_t;

    vec_t        vt [6];
    logic [29:0] e;
    logic [5:0]  seen [$];

    initial begin
        vt[0] = '{EX_ALU,  1'b0, 6'd17, 5'd3,  2};
        vt[1] = '{EX_MULT, 1'b1, 6'd0,  5'd31, 5};
        vt[2] = '{EX_LD,   1'b0, 6'd63, 5'd0,  3};
        vt[3] = '{EX_SV,   1'b1, 6'd44, 5'd9,  2};
        vt[4] = '{3'd5,    1'b0, 6'd21, 5'd4,  0};
        vt[5] = '{3'd7,    1'b1, 6'd22, 5'd6,  0};

        idle();
        #2;
        apply_reset(2);

        // Isolated single issues: exact latency, one-cycle pulse, reserved types ignored
        for (int i = 0; i < 6; i++) begin
            apply_reset(1);
            if (vt[i].portb) drive(1'b0, 3'd0, 6'd0, 5'd0, 1'b1, vt[i].typ, vt[i].tag, vt[i].rob);
            else             drive(1'b1, vt[i].typ, vt[i].tag, vt[i].rob, 1'b0, 3'd0, 6'd0, 5'd0);
            cycle();
            idle();
            for (int c = 1; c <= 7; c++) begin
                cycle();
                e = '0;
                if (c == vt[i].lat)
                    e = (vt[i].typ == EX_SV) ? {24'd0, 1'b1, vt[i].rob}
                                             : {1'b1, vt[i].tag, vt[i].rob, 18'd0};
                check($sformatf("vec%0d_c%0d", i, c), 64'(cdb_obs()), 64'(e));
            end
        end

        // Arbitration: LD > MULT > ALU, ALU waits one cycle
        apply_reset(1);
        drive(1'b1, EX_MULT, 6'd12, 5'd1, 1'b0, 3'd0, 6'd0, 5'd0); cycle();
        idle();                                                     cycle();
        drive(1'b1, EX_LD, 6'd9, 5'd2, 1'b0, 3'd0, 6'd0, 5'd0);     cycle();
        drive(1'b1, EX_ALU, 6'd5, 5'd3, 1'b0, 3'd0, 6'd0, 5'd0);    cycle();
        idle();                                                     cycle();
        cycle();
        check("arb_E5", 64'({ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx}),
              64'({1'b1, 6'd9, 1'b1, 6'd12}));
        cycle();
        check("arb_E6", 64'({ex_cm_cdbA_en, ex_cm_cdbAIdx, ex_cm_cdbB_en, ex_cm_cdbBIdx}),
              64'({1'b1, 6'd5, 1'b0, 6'd0}));

        // MULT back-pressure
        apply_reset(1);
        drive(1'b1, EX_MULT, 6'd1, 5'd1, 1'b1, EX_MULT, 6'd2, 5'd2); cycle();
        check("mulfull_E0", 64'(ex_mulq_full), 64'(0));
        drive(1'b1, EX_MULT, 6'd3, 5'd3, 1'b1, EX_MULT, 6'd4, 5'd4); cycle();
        check("mulfull_E1", 64'(ex_mulq_full), 64'(1));
        idle();
        repeat (3) cycle();
        cycle();
        check("mulfull_E5", 64'(ex_mulq_full), 64'(1));
        cycle();
        check("mulfull_E6", 64'(ex_mulq_full), 64'(0));

        // Overflow: fifth MULT dropped, the other four broadcast in order
        apply_reset(1);
        drive(1'b1, EX_MULT, 6'd1, 5'd1, 1'b1, EX_MULT, 6'd2, 5'd2); cycle();
        drive(1'b1, EX_MULT, 6'd3, 5'd3, 1'b1, EX_MULT, 6'd4, 5'd4); cycle();
        drive(1'b1, EX_MULT, 6'd20, 5'd5, 1'b0, 3'd0, 6'd0, 5'd0);   cycle();
        idle();
        seen.delete();
        for (int c = 0; c < 12; c++) begin
            cycle();
            check("ovf_sticky", 64'(ex_overflow), 64'(1));
            if (ex_cm_cdbA_en) seen.push_back(ex_cm_cdbAIdx);
            if (ex_cm_cdbB_en) seen.push_back(ex_cm_cdbBIdx);
        end
        check("ovf_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < seen.size() && i < 4; i++)
            check($sformatf("ovf_order%0d", i), 64'(seen[i]), 64'(i + 1));

        // Two stores on A/B: one completion per cycle, CDB untouched
        apply_reset(1);
        drive(1'b1, EX_SV, 6'd30, 5'd7, 1'b1, EX_SV, 6'd31, 5'd8); cycle();
        idle();
        for (int c = 1; c <= 5; c++) begin
            cycle();
            check($sformatf("sv_cdb_c%0d", c), 64'({ex_cm_cdbA_en, ex_cm_cdbB_en}), 64'(0));
            check($sformatf("sv_done_c%0d", c), 64'({ex_sv_done, ex_sv_robIdx}),
                  (c == 2) ? 64'({1'b1, 5'd7}) : (c == 3) ? 64'({1'b1, 5'd8}) : 64'(0));
        end

        // Reset mid-traffic: nothing pre-reset may ever broadcast
        apply_reset(1);
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, EX_MULT, 6'(40 + c), 5'(c), 1'b1, EX_LD, 6'(50 + c), 5'(c + 8));
            cycle();
        end
        apply_reset(2);
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("post_reset_quiet", 64'(obs()), 64'(0));
        end

        // Randomized traffic against the model, with one reset in the middle
        apply_reset(1);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) apply_reset(1);
            drive($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 6'($urandom), 5'($urandom),
                  $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 6'($urandom), 5'($urandom));
            cycle();
        end
        idle();
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
